// File: rtl/multi_ch_timer.sv
// Multi-channel programmable interval timer: one shared prescaler produces a
// base tick, and NUM_CH independent down-counters count it in one-shot or periodic mode.
module multi_ch_timer #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PRE_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  output logic                    tick,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH*CNT_W-1:0] count
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [PRE_W-1:0] pre_cnt;

  // Free-running prescaler; tick follows the cycle where the counter holds its last value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (pre_cnt == PRE_LAST);
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rel_q, rel_d;
    logic [CNT_W-1:0] load_eff;
    logic             mode_q, mode_d;
    logic             to_q, to_d;
    logic             run_q;

    // A zero interval is treated as one tick
    assign load_eff = (load_val[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                         : load_val[i*CNT_W +: CNT_W];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rel_q   <= '0;
        mode_q  <= 1'b0;
        to_q    <= 1'b0;
        run_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rel_q   <= rel_d;
        mode_q  <= mode_d;
        to_q    <= to_d;
        run_q   <= (state_d == RUN);
      end
    end

    // Priority: stop, then start, then the base tick
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rel_d   = rel_q;
      mode_d  = mode_q;
      to_d    = 1'b0;
      if (stop[i]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (start[i]) begin
        state_d = RUN;
        cnt_d   = load_eff;
        rel_d   = load_eff;
        mode_d  = periodic[i];
      end else begin
        case (state_q)
          RUN: begin
            if (tick) begin
              if (cnt_q > CNT_W'(1)) begin
                cnt_d = cnt_q - CNT_W'(1);
              end else begin
                to_d = 1'b1;
                if (mode_q) begin
                  cnt_d = rel_q;
                end else begin
                  cnt_d   = '0;
                  state_d = IDLE;
                end
              end
            end
          end
          default: cnt_d = '0;
        endcase
      end
    end

    assign timeout[i]               = to_q;
    assign running[i]               = run_q;
    assign count[i*CNT_W +: CNT_W]  = cnt_q;
  end

endmodule

// File: tb/tb_multi_ch_timer.sv
// Self-checking bench for multi_ch_timer: directed scenarios plus a random phase,
// compared every cycle against a behavioural model of the timer.
module tb_multi_ch_timer;
  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PRE_W    = 8;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0]       start, stop, periodic;
  logic [NUM_CH*CNT_W-1:0] load_val;
  logic                    tick;
  logic [NUM_CH-1:0]       timeout, running;
  logic [NUM_CH*CNT_W-1:0] count;

  multi_ch_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(PRESCALE), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .periodic(periodic),
    .load_val(load_val), .tick(tick), .timeout(timeout), .running(running), .count(count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  int unsigned m_edges;
  bit          m_tick;
  bit          m_to  [NUM_CH];
  bit          m_run [NUM_CH];
  bit          m_per [NUM_CH];
  int unsigned m_cnt [NUM_CH];
  int unsigned m_rel [NUM_CH];

  int cyc;
  int last_to [NUM_CH];
  int last_gap[NUM_CH];
  int to_cnt  [NUM_CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_edges = 0;
    m_tick  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_to[c] = 0; m_run[c] = 0; m_per[c] = 0; m_cnt[c] = 0; m_rel[c] = 0;
      last_to[c] = -1; last_gap[c] = 0; to_cnt[c] = 0;
    end
  endtask

  // One clock edge of the timer as described by its rules
  task automatic model_edge();
    int unsigned l;
    for (int c = 0; c < NUM_CH; c++) begin
      m_to[c] = 0;
      l = load_val[c*CNT_W +: CNT_W];
      if (l == 0) l = 1;
      if (stop[c]) begin
        m_run[c] = 0; m_cnt[c] = 0;
      end else if (start[c]) begin
        m_run[c] = 1; m_cnt[c] = l; m_rel[c] = l; m_per[c] = periodic[c];
      end else if (m_run[c] && m_tick) begin
        if (m_cnt[c] > 1) m_cnt[c]--;
        else begin
          m_to[c] = 1;
          if (m_per[c]) m_cnt[c] = m_rel[c];
          else begin m_cnt[c] = 0; m_run[c] = 0; end
        end
      end
    end
    m_edges++;
    m_tick = (m_edges % PRESCALE) == 0;
  endtask

  task automatic step();
    logic [NUM_CH*CNT_W-1:0] exp_cnt;
    logic [NUM_CH-1:0]       exp_to, exp_run;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
      exp_to[c]  = m_to[c];
      exp_run[c] = m_run[c];
    end
    check("tick", 64'(tick), 64'(m_tick));
    check("timeout", 64'(timeout), 64'(exp_to));
    check("running", 64'(running), 64'(exp_run));
    check("count", 64'(count), 64'(exp_cnt));
    for (int c = 0; c < NUM_CH; c++) begin
      if (timeout[c]) begin
        if (last_to[c] >= 0) last_gap[c] = cyc - last_to[c];
        last_to[c] = cyc;
        to_cnt[c]++;
      end
    end
    start = '0;
    stop  = '0;
  endtask

  task automatic do_reset();
    start = '0; stop = '0; periodic = '0; load_val = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    model_clear();
    cyc = 0;
    check("rst_tick", 64'(tick), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_count", 64'(count), 64'd0);
  endtask

  task automatic set_load(input int c, input int unsigned v);
    load_val[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  initial begin
    int s;
    int t;
    int k;
    int pairs;
    bit got;

    do_reset();

    // Prescaler cadence: tick high at cycles 4, 8, 12
    for (int i = 0; i < 12; i++) begin
      step();
      if (cyc % 4 == 0) check("tick_cadence", 64'(tick), 64'd1);
    end

    // ch0 one-shot, L=3, arbitrary phase
    repeat ($urandom_range(0, 3)) step();
    for (int c = 0; c < NUM_CH; c++) to_cnt[c] = 0;
    set_load(0, 3); periodic[0] = 1'b0; start[0] = 1'b1;
    step();
    s = cyc;
    check("os_running", 64'(running[0]), 64'd1);
    check("os_count_start", 64'(count[CNT_W-1:0]), 64'd3);
    got = 0;
    for (k = 0; k < 20 && !got; k++) begin
      step();
      if (timeout[0]) begin got = 1; t = cyc; end
    end
    check("os_seen", 64'(got), 64'd1);
    check("os_window", 64'((t - s) >= 9 && (t - s) <= 12), 64'd1);
    repeat (10) step();
    check("os_single_pulse", 64'(to_cnt[0]), 64'd1);
    check("os_idle", 64'(running[0]), 64'd0);

    // ch1 periodic, L=2: pulses 8 cycles apart
    set_load(1, 2); periodic[1] = 1'b1; start[1] = 1'b1;
    step();
    to_cnt[1] = 0; last_to[1] = -1;
    for (k = 0; k < 100 && to_cnt[1] < 6; k++) begin
      step();
      if (timeout[1] && to_cnt[1] > 1) check("per_gap", 64'(last_gap[1]), 64'd8);
    end
    check("per_six_pulses", 64'(to_cnt[1]), 64'd6);
    check("per_running", 64'(running[1]), 64'd1);
    stop[1] = 1'b1;
    step();
    check("per_stop_running", 64'(running[1]), 64'd0);
    t = to_cnt[1];
    repeat (12) step();
    check("per_no_pulse_after_stop", 64'(to_cnt[1]), 64'(t));

    // load_val=0 behaves as 1
    set_load(0, 0); periodic[0] = 1'b0; start[0] = 1'b1;
    step();
    s = cyc; got = 0;
    for (k = 0; k < 10 && !got; k++) begin
      step();
      if (timeout[0]) begin got = 1; t = cyc; end
    end
    check("zero_seen", 64'(got), 64'd1);
    check("zero_window", 64'((t - s) >= 1 && (t - s) <= 4), 64'd1);

    // restart mid-run retimes the interval
    set_load(0, 3); start[0] = 1'b1;
    step();
    repeat (2) step();
    set_load(0, 5); start[0] = 1'b1;
    step();
    check("restart_count", 64'(count[CNT_W-1:0]), 64'd5);
    check("restart_no_pulse", 64'(timeout[0]), 64'd0);
    stop[0] = 1'b1;
    step();

    // simultaneous start and stop stays idle
    set_load(0, 4); start[0] = 1'b1; stop[0] = 1'b1;
    step();
    check("start_stop_idle", 64'(running[0]), 64'd0);

    // stop on the expiry tick suppresses the pulse
    set_load(0, 1); periodic[0] = 1'b1; start[0] = 1'b1;
    step();
    for (k = 0; k < 10 && !(m_tick && m_cnt[0] == 1); k++) step();
    check("expiry_tick_found", 64'(m_tick && m_cnt[0] == 1), 64'd1);
    stop[0] = 1'b1;
    step();
    check("stop_at_expiry_no_pulse", 64'(timeout[0]), 64'd0);
    check("stop_at_expiry_idle", 64'(running[0]), 64'd0);

    // both channels periodic L=1: joint pulses on every tick
    set_load(0, 1); set_load(1, 1); periodic = 2'b11; start = 2'b11;
    step();
    pairs = 0;
    repeat (16) begin
      step();
      if (timeout == 2'b11) pairs++;
    end
    check("joint_pulses", 64'(pairs), 64'd4);

    // asynchronous reset mid-run
    reset_n = 1'b0;
    #1;
    check("async_rst_tick", 64'(tick), 64'd0);
    check("async_rst_timeout", 64'(timeout), 64'd0);
    check("async_rst_running", 64'(running), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    do_reset();

    // random phase against the model
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          start[c] = 1'b1;
          periodic[c] = 1'($urandom_range(0, 1));
          set_load(c, $urandom_range(0, 5));
        end
        if ($urandom_range(0, 24) == 0) stop[c] = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_ch_timer.md
Name: multi_ch_timer

Overview:
- Multi-channel programmable interval timer for the next generation of the design's timing blocks.
- Built around one shared free-running prescaler that produces a base tick.
- NUM_CH independent down-counters count base ticks; each can run one-shot or periodic and is started/stopped by control logic.
- Each channel raises a one-cycle timeout pulse toward FSMs, LED drivers and game-logic sequencers.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16).
- CNT_W, 32, width of each channel's interval/count register.
- PRESCALE, 50000, clk cycles per base tick (1 ms at 50 MHz); must be >= 2.
- PRE_W, 32, width of prescaler counter; must hold PRESCALE-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  NUM_CH  per-channel start/restart strobe, 1 cycle.
- stop  in  NUM_CH  per-channel stop strobe, 1 cycle.
- periodic  in  NUM_CH  per-channel mode, sampled at start: 1 = auto-reload, 0 = one-shot.
- load_val  in  NUM_CH*CNT_W  interval in base ticks; channel i uses bits [i*CNT_W +: CNT_W].
- tick  out  1  base tick strobe, high 1 cycle every PRESCALE cycles.
- timeout  out  NUM_CH  per-channel expiry pulse, registered, 1 cycle.
- running  out  NUM_CH  channel is in RUN state.
- count  out  NUM_CH*CNT_W  current remaining ticks per channel, same packing as load_val.

Behaviour:
- Reset, asynchronous on reset_n low: prescaler=0, tick=0, every channel IDLE, count=0, reload=0, mode=one-shot, timeout=0, running=0. Reset mid-count aborts with no timeout.
- Prescaler:
  - Free-running from reset, independent of channel activity; counts 0..PRESCALE-1 and wraps.
  - tick is registered: high for the cycle after the prescaler holds PRESCALE-1, so ticks are exactly PRESCALE cycles apart.
  - First tick is high PRESCALE cycles after reset release.
- Channel FSM has two states, IDLE and RUN. Per-cycle priority: stop > start > tick.
  - stop, any state: go to IDLE, count<=0, running<=0, no timeout. Applies even with simultaneous start, or on the count==1 expiry tick; that tick's timeout is suppressed.
  - start, IDLE or RUN: go to RUN.
    - count<=L and reload<=L, where L = load_val, or 1 if load_val==0.
    - mode<=periodic.
    - Any tick in the same cycle is ignored.
    - A start in RUN restarts the interval with no timeout.
  - tick in RUN, count>1: count<=count-1.
  - tick in RUN, count==1: timeout high for the next cycle.
    - Periodic: count<=reload, stay in RUN.
    - One-shot: count<=0, go to IDLE, running<=0.
  - IDLE ignores tick; count holds 0.
- Timing:
  - running rises the cycle after start is sampled.
  - Start-to-first-timeout: between (L-1)*PRESCALE+1 and L*PRESCALE cycles, depending on prescaler phase.
  - Periodic timeouts thereafter are exactly L*PRESCALE cycles apart.
- Changes to load_val or periodic while in RUN have no effect until the next start.
- Channels are fully independent. Several channels may time out in the same cycle; each asserts its own bit.
- Count is unsigned CNT_W. No overflow is possible since it only decrements from L.
- timeout, running and count are all registered outputs; no combinational path from inputs.

Test Plan:
- PRESCALE=4, NUM_CH=2. Reset release, then observe tick -> first tick high at cycle 4 after release, then at 8, 12, ... for exactly 1 cycle each.
- ch0 one-shot, load_val=3, start at arbitrary phase -> running=1 next cycle; count steps 3,2,1; one timeout pulse 9..12 cycles after start; then running=0, count=0, no further pulses.
- ch1 periodic, load_val=2 -> timeouts exactly 8 cycles apart for 5 periods; count cycles 2,1,2,1; running stays 1. Then stop -> running=0 next cycle, no further timeout.
- load_val=0 with start -> behaves as 1: timeout within 1..4 cycles. Start again mid-run with load_val=5 -> no pulse, count=5, expiry re-timed.
- Simultaneous start+stop on ch0 -> stays IDLE. Stop in the same cycle as the count==1 tick -> no timeout.
- Both channels periodic, load_val=1 -> simultaneous timeout=2'b11 on every tick. Assert reset_n low mid-run -> all outputs 0 asynchronously, before the next clk edge.
